// File: rtl/aud_pkg.sv
// Shared constants and types for the I2S audio player.
package aud_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int FILL_W     = PTR_W + 1;
   localparam int BIT_CNT_W  = $clog2(SAMPLE_W);

   typedef logic [SAMPLE_W-1:0] sample_t;

   // Slot sequencer states: SYNC waits for the first left edge so a word
   // is never started part-way through a frame.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEFT,
      ST_PADL,
      ST_RIGHT,
      ST_PADR
   } state_e;

endpackage

// File: rtl/aud_sample_fifo.sv
// Small sample FIFO with registered fill count. Push/pop requests are
// qualified internally against full/empty; flush overrides both.
module aud_sample_fifo
   import aud_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  sample_t           i_data,
   input  logic              i_pop,
   input  logic              i_flush,
   output sample_t           o_head,
   output logic [FILL_W-1:0] o_fill,
   output logic              o_full,
   output logic              o_empty
);

   sample_t           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              do_push, do_pop;

   assign o_full  = (fill_q == FILL_W'(FIFO_DEPTH));
   assign o_empty = (fill_q == '0);
   assign do_push = i_push & ~o_full & ~i_flush;
   assign do_pop  = i_pop & ~o_empty & ~i_flush;
   assign o_head  = mem_q[rd_ptr_q];
   assign o_fill  = fill_q;

   // Next pointers and occupancy; pointers wrap naturally at the depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Sample storage; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end

endmodule

// File: rtl/aud_player.sv
// I2S DAC player: buffers mono samples and serialises each one into both
// the left and right slots, MSB first, one bit clock after the LRCK edge.
module aud_player
   import aud_pkg::*;
(
   input  logic                i_bclk,
   input  logic                daclrck,
   input  logic                i_lrck,
   input  logic                i_en,
   input  logic                i_flush,
   input  logic                i_clr_underrun,
   input  logic [SAMPLE_W-1:0] i_data,
   input  logic                i_valid,
   output logic                o_ready,
   output logic                o_dacdat,
   output logic [FILL_W-1:0]   o_fill,
   output logic                o_underrun
);

   state_e               state_q;
   logic                 lrck_q;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   sample_t              shift_q;
   sample_t              sample_q;
   sample_t              fifo_head;
   sample_t              next_sample;
   logic                 fifo_full, fifo_empty;
   logic                 lrck_fall, lrck_rise;
   logic                 enter_left, underrun_set;
   logic                 underrun_q, dacdat_q;

   assign lrck_fall    = lrck_q & ~i_lrck;
   assign lrck_rise    = ~lrck_q & i_lrck;
   // A left word only ever starts from SYNC or the right pad slot.
   assign enter_left   = i_en & lrck_fall & ((state_q == ST_SYNC) | (state_q == ST_PADR));
   assign underrun_set = enter_left & fifo_empty;
   assign next_sample  = fifo_empty ? '0 : fifo_head;
   assign o_ready      = ~fifo_full;
   assign o_underrun   = underrun_q;
   assign o_dacdat     = dacdat_q;

   aud_sample_fifo u_fifo (
      .i_clk   (i_bclk),
      .i_rst   (daclrck),
      .i_push  (i_valid),
      .i_data  (i_data),
      .i_pop   (enter_left),
      .i_flush (i_flush),
      .o_head  (fifo_head),
      .o_fill  (o_fill),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Slot sequencer: edge tracking, word load and MSB-first shifting.
   always_ff @(posedge i_bclk or posedge daclrck) begin
      if (daclrck) begin
         state_q   <= ST_IDLE;
         lrck_q    <= 1'b0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         sample_q  <= '0;
      end else begin
         lrck_q <= i_lrck;
         if (!i_en) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_SYNC;
               ST_SYNC, ST_PADR: begin
                  if (enter_left) begin
                     state_q   <= ST_LEFT;
                     sample_q  <= next_sample;
                     shift_q   <= next_sample;
                     bit_cnt_q <= '0;
                  end
               end
               ST_LEFT: begin
                  shift_q   <= shift_q << 1;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == '1) state_q <= ST_PADL;
               end
               ST_PADL: begin
                  if (lrck_rise) begin
                     state_q   <= ST_RIGHT;
                     shift_q   <= sample_q;
                     bit_cnt_q <= '0;
                  end
               end
               ST_RIGHT: begin
                  shift_q   <= shift_q << 1;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == '1) state_q <= ST_PADR;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Sticky underrun: flush clears, a new underrun beats a same-cycle clear.
   always_ff @(posedge i_bclk or posedge daclrck) begin
      if (daclrck)             underrun_q <= 1'b0;
      else if (i_flush)        underrun_q <= 1'b0;
      else if (underrun_set)   underrun_q <= 1'b1;
      else if (i_clr_underrun) underrun_q <= 1'b0;
   end

   // Serial data changes on the falling edge so the DAC samples it mid-bit.
   always_ff @(negedge i_bclk or posedge daclrck) begin
      if (daclrck) dacdat_q <= 1'b0;
      else         dacdat_q <= ((state_q == ST_LEFT) || (state_q == ST_RIGHT)) ? shift_q[SAMPLE_W-1] : 1'b0;
   end

endmodule

// File: tb/tb_aud_player.sv
// Self-checking bench for aud_player with a slot-level reference model.
module tb_aud_player;

   logic        i_bclk = 1'b0;
   logic        daclrck, i_lrck, i_en, i_flush, i_clr_underrun, i_valid;
   logic [15:0] i_data;
   logic        o_ready, o_dacdat, o_underrun;
   logic [2:0]  o_fill;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [15:0] mq[$];
   bit          m_ur, m_active, m_framed, m_lrck_prev;
   logic [15:0] m_slot;
   int          cyc = 0, slot_start = 0, slot_end = 0;
   bit          lrck_run;
   int          lrck_cnt;

   always #5 i_bclk = ~i_bclk;

   aud_player dut (
      .i_bclk         (i_bclk),
      .daclrck        (daclrck),
      .i_lrck         (i_lrck),
      .i_en           (i_en),
      .i_flush        (i_flush),
      .i_clr_underrun (i_clr_underrun),
      .i_data         (i_data),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .o_dacdat       (o_dacdat),
      .o_fill         (o_fill),
      .o_underrun     (o_underrun)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected serial bit: a slot starting at rising edge S shows bit 15 after edge S+1.
   function automatic logic exp_dat();
      if (cyc > slot_start && cyc <= slot_end) return m_slot[15-(cyc-slot_start-1)];
      return 1'b0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ur = 0; m_active = 0; m_framed = 0; m_lrck_prev = 0;
      slot_start = 0; slot_end = 0;
   endtask

   task automatic model_step();
      bit fall, rise, set_ur;
      int sz;
      if (daclrck) begin model_reset(); return; end
      fall = m_lrck_prev && !i_lrck;
      rise = !m_lrck_prev && i_lrck;
      m_lrck_prev = i_lrck;
      sz = mq.size();
      set_ur = 0;
      if (!i_en) begin
         m_active = 0; m_framed = 0;
         if (slot_end > cyc) slot_end = cyc;
      end else if (!m_active) begin
         m_active = 1; m_framed = 0;
      end else if (fall) begin
         if (sz == 0) begin m_slot = 16'h0000; set_ur = 1; end
         else m_slot = mq.pop_front();
         m_framed = 1; slot_start = cyc; slot_end = cyc + 16;
      end else if (rise && m_framed) begin
         slot_start = cyc; slot_end = cyc + 16;
      end
      if (i_flush) begin
         mq.delete(); m_ur = 0;
      end else begin
         if (i_valid && sz < 4) mq.push_back(i_data);
         if (set_ur) m_ur = 1;
         else if (i_clr_underrun) m_ur = 0;
      end
   endtask

   // One bit clock: advance LRCK, let both DUT and model see the edge, settle.
   task automatic cycle();
      if (lrck_run) begin
         lrck_cnt = (lrck_cnt + 1) % 64;
         i_lrck = (lrck_cnt >= 32);
      end
      @(posedge i_bclk);
      cyc++;
      model_step();
      #1;
   endtask

   task automatic test_reset();
      daclrck = 1; i_en = 0; i_flush = 0; i_clr_underrun = 0; i_valid = 0; i_data = '0;
      i_lrck = 0; lrck_run = 0; lrck_cnt = 0;
      model_reset();
      repeat (3) cycle();
      n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL reset_fill got=%0d exp=0", o_fill); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      n_cmp++; if (o_dacdat !== 1'b0) begin n_bad++; $display("FAIL reset_dacdat got=%b exp=0", o_dacdat); end
      n_cmp++; if (o_underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got=%b exp=0", o_underrun); end
      daclrck = 0;
      cycle();
   endtask

   task automatic test_single();
      logic [15:0] word;
      int nslot;
      word = '0; nslot = 0;
      i_en = 1; lrck_run = 1; lrck_cnt = 40;
      i_data = 16'hA5C3; i_valid = 1; cycle(); i_valid = 0;
      repeat (150) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL single_dacdat cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         n_cmp++; if (o_fill !== 3'(mq.size())) begin n_bad++; $display("FAIL single_fill cyc=%0d got=%0d exp=%0d", cyc, o_fill, mq.size()); end
         if (cyc > slot_start && cyc <= slot_end) begin
            word = {word[14:0], o_dacdat};
            if (cyc == slot_start + 16 && nslot < 2) begin
               nslot++;
               n_cmp++; if (word !== 16'hA5C3) begin n_bad++; $display("FAIL single_word slot=%0d got=%h exp=a5c3", nslot, word); end
            end
         end
      end
   endtask

   task automatic test_underrun();
      n_cmp++; if (o_underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set got=%b exp=1", o_underrun); end
      repeat (4) cycle();
      i_clr_underrun = 1; cycle(); i_clr_underrun = 0;
      n_cmp++; if (o_underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clr got=%b exp=0", o_underrun); end
      for (int k = 0; k < 100 && lrck_cnt != 63; k++) cycle();
      // empty pop, push and clear all on the same edge
      i_clr_underrun = 1; i_valid = 1; i_data = 16'($urandom); cycle();
      i_clr_underrun = 0; i_valid = 0;
      n_cmp++; if (o_underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_prio got=%b exp=1", o_underrun); end
      n_cmp++; if (o_fill !== 3'd1) begin n_bad++; $display("FAIL underrun_pushkept got=%0d exp=1", o_fill); end
      repeat (140) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL underrun_dacdat cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         n_cmp++; if (o_underrun !== m_ur) begin n_bad++; $display("FAIL underrun_flag cyc=%0d got=%b exp=%b", cyc, o_underrun, m_ur); end
      end
   endtask

   task automatic test_fill();
      i_en = 0; i_flush = 1; cycle(); i_flush = 0;
      for (int k = 0; k < 5; k++) begin
         i_data = 16'($urandom); i_valid = 1; cycle();
         n_cmp++; if (o_fill !== 3'(mq.size())) begin n_bad++; $display("FAIL fill_count push=%0d got=%0d exp=%0d", k, o_fill, mq.size()); end
         n_cmp++; if (o_ready !== (mq.size() < 4)) begin n_bad++; $display("FAIL fill_ready push=%0d got=%b exp=%b", k, o_ready, mq.size() < 4); end
      end
      i_valid = 0;
      n_cmp++; if (o_fill !== 3'd4) begin n_bad++; $display("FAIL fill_full got=%0d exp=4", o_fill); end
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fill_notready got=%b exp=0", o_ready); end
      i_en = 1;
      repeat (330) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL fill_dacdat cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         n_cmp++; if (o_fill !== 3'(mq.size())) begin n_bad++; $display("FAIL fill_drain cyc=%0d got=%0d exp=%0d", cyc, o_fill, mq.size()); end
      end
   endtask

   task automatic test_disable();
      int k;
      for (int j = 0; j < 2; j++) begin i_data = 16'($urandom); i_valid = 1; cycle(); end
      i_valid = 0;
      for (k = 0; k < 200; k++) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL dis_pre cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         if (cyc == slot_start && !i_lrck && m_framed) break;
      end
      n_cmp++; if (k >= 200) begin n_bad++; $display("FAIL dis_wait got=timeout exp=left slot start"); end
      repeat (9) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL dis_bits cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
      end
      i_en = 0;
      for (int j = 0; j < 12; j++) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL dis_off cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         if (j >= 1) begin
            n_cmp++; if (o_dacdat !== 1'b0) begin n_bad++; $display("FAIL dis_zero cyc=%0d got=%b exp=0", cyc, o_dacdat); end
         end
      end
      n_cmp++; if (o_fill !== 3'd1) begin n_bad++; $display("FAIL dis_kept got=%0d exp=1", o_fill); end
      i_en = 1;
      repeat (150) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL dis_resume cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
      end
   endtask

   task automatic test_reset_mid_right();
      int k;
      for (int j = 0; j < 3; j++) begin i_data = 16'($urandom); i_valid = 1; cycle(); end
      i_valid = 0;
      for (k = 0; k < 200; k++) begin
         cycle();
         if (cyc == slot_start && i_lrck && m_framed) break;
      end
      n_cmp++; if (k >= 200) begin n_bad++; $display("FAIL rst_wait got=timeout exp=right slot start"); end
      repeat (5) cycle();
      daclrck = 1; #1;
      n_cmp++; if (o_dacdat !== 1'b0) begin n_bad++; $display("FAIL rst_mid_dacdat got=%b exp=0", o_dacdat); end
      n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL rst_mid_fill got=%0d exp=0", o_fill); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got=%b exp=1", o_ready); end
      n_cmp++; if (o_underrun !== 1'b0) begin n_bad++; $display("FAIL rst_mid_underrun got=%b exp=0", o_underrun); end
      model_reset();
      repeat (3) cycle();
      daclrck = 0;
      i_data = 16'($urandom); i_valid = 1; cycle(); i_valid = 0;
      repeat (150) begin
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL rst_resume cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         n_cmp++; if (o_fill !== 3'(mq.size())) begin n_bad++; $display("FAIL rst_fill cyc=%0d got=%0d exp=%0d", cyc, o_fill, mq.size()); end
      end
   endtask

   task automatic test_flush();
      i_en = 1; i_flush = 1; cycle(); i_flush = 0;
      for (int k = 0; k < 100 && lrck_cnt != 63; k++) cycle();
      cycle();
      n_cmp++; if (o_underrun !== 1'b1) begin n_bad++; $display("FAIL flush_pre_underrun got=%b exp=1", o_underrun); end
      i_en = 0;
      for (int k = 0; k < 3; k++) begin i_data = 16'($urandom); i_valid = 1; cycle(); end
      n_cmp++; if (o_fill !== 3'd3) begin n_bad++; $display("FAIL flush_pre_fill got=%0d exp=3", o_fill); end
      i_flush = 1; i_data = 16'($urandom); i_valid = 1; cycle();
      i_flush = 0; i_valid = 0;
      n_cmp++; if (o_fill !== 3'd0) begin n_bad++; $display("FAIL flush_fill got=%0d exp=0", o_fill); end
      n_cmp++; if (o_underrun !== 1'b0) begin n_bad++; $display("FAIL flush_underrun got=%b exp=0", o_underrun); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
   endtask

   task automatic test_random();
      int off_cnt;
      off_cnt = 0;
      i_en = 1;
      repeat (1200) begin
         i_valid = ($urandom_range(0, 29) == 0);
         i_data = 16'($urandom);
         i_clr_underrun = ($urandom_range(0, 49) == 0);
         i_flush = ($urandom_range(0, 299) == 0);
         if (off_cnt > 0) off_cnt--;
         else if ($urandom_range(0, 399) == 0) off_cnt = 10;
         i_en = (off_cnt == 0);
         cycle();
         n_cmp++; if (o_dacdat !== exp_dat()) begin n_bad++; $display("FAIL rnd_dacdat cyc=%0d got=%b exp=%b", cyc, o_dacdat, exp_dat()); end
         n_cmp++; if (o_fill !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", cyc, o_fill, mq.size()); end
         n_cmp++; if (o_ready !== (mq.size() < 4)) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, o_ready, mq.size() < 4); end
         n_cmp++; if (o_underrun !== m_ur) begin n_bad++; $display("FAIL rnd_underrun cyc=%0d got=%b exp=%b", cyc, o_underrun, m_ur); end
      end
      i_valid = 0; i_clr_underrun = 0; i_flush = 0; i_en = 1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_underrun();
      test_fill();
      test_disable();
      test_reset_mid_right();
      test_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aud_player.md
AUD_PLAYER -- requirements
Module: aud_player

Interface
REQ-001 SHALL have port i_bclk, in, 1, I2S bit clock; all sequential logic is on its rising edge except o_dacdat.
REQ-002 SHALL have port daclrck, in, 1, reset daclrck, asynchronous, active-high.
REQ-003 SHALL have port i_lrck, in, 1, DAC LR clock, synchronous to i_bclk: low = left, high = right.
REQ-004 SHALL have port i_en, in, 1, play enable.
REQ-005 SHALL have port i_flush, in, 1, single-cycle FIFO clear.
REQ-006 SHALL have port i_clr_underrun, in, 1, clears o_underrun.
REQ-007 SHALL have port i_data, in, 16, signed sample from AudDSP o_dac_data.
REQ-008 SHALL have port i_valid, in, 1, i_data valid.
REQ-009 SHALL have port o_ready, out, 1, FIFO can accept.
REQ-010 SHALL have port o_dacdat, out, 1, serial DAC data.
REQ-011 SHALL have port o_fill, out, 3, FIFO occupancy 0..4.
REQ-012 SHALL have port o_underrun, out, 1, sticky underrun flag.

Function
REQ-013 SHALL buffer samples in a 4-entry FIFO; push = i_valid & o_ready; o_ready = (fill < 4).
REQ-014 SHALL detect LRCK edges with a registered copy lrck_q: fall = lrck_q & ~i_lrck, rise = ~lrck_q & i_lrck.
REQ-015 SHALL implement states IDLE, SYNC, LEFT, PADL, RIGHT, PADR.
REQ-016 SHALL go IDLE->SYNC when i_en=1; SYNC->LEFT on fall; LEFT->PADL after 16 bits; PADL->RIGHT on rise; RIGHT->PADR after 16 bits; PADR->LEFT on fall.
REQ-017 SHALL, on each transition into LEFT, pop one FIFO entry into the 16-bit shift register; if the FIFO is empty it loads 0x0000 and sets o_underrun.
REQ-018 SHALL, on transition into RIGHT, reload the same sample (mono duplicated to both channels).
REQ-019 SHALL shift MSB-first and update o_dacdat on the falling i_bclk edge from the shift-register MSB.
REQ-020 SHALL make bit 15 valid at the rising edge one cycle after the edge that detects the LRCK transition (I2S one-bit delay).
REQ-021 SHALL drive o_dacdat=0 in IDLE, SYNC, PADL and PADR.
REQ-022 SHALL force IDLE on the next rising edge when i_en=0, including mid-word; FIFO contents are kept.
REQ-023 SHALL, on i_flush, empty the FIFO and clear o_underrun; flush has priority over simultaneous push and pop.
REQ-024 SHALL let a pop on an empty FIFO count as underrun even if a push occurs in the same cycle; the pushed sample is kept.
REQ-025 SHALL give i_clr_underrun lower priority than a same-cycle underrun set.
REQ-026 SHALL make o_fill reflect the registered occupancy; a simultaneous push and pop leaves it unchanged.

Reset
REQ-027 SHALL, on daclrck, asynchronously set state IDLE, FIFO empty, o_fill=0, o_ready=1, o_dacdat=0, o_underrun=0, lrck_q=0 and bit counter 0.
REQ-028 SHALL resume only via SYNC after reset release; no partial word is ever emitted.

Structure
REQ-029 SHALL place SAMPLE_W=16, FIFO_DEPTH=4 and the state enum in shared package aud_pkg.
REQ-030 SHALL implement the FIFO as sub-module aud_sample_fifo (push/pop/flush/fill, pointer wrap modulo 4).

Verification
REQ-031 SHALL cover this scenario: push 0xA5C3 with i_en=1 and LRCK period 64 bclk -> left and right slots each serialize 1010010111000011 starting one bclk after the edge, then zeros.
REQ-032 SHALL cover this scenario: push 5 samples with no playback -> o_ready=0 after the 4th, o_fill=4, and the 5th sample is not accepted.
REQ-033 SHALL cover this scenario: empty FIFO at a left-channel LRCK fall -> 0x0000 is output and o_underrun=1 until i_clr_underrun.
REQ-034 SHALL cover this scenario: i_en dropped at bit 7 of the left slot -> o_dacdat=0 from the next falling edge; on re-enable nothing is output until the next LRCK fall.
REQ-035 SHALL cover this scenario: daclrck asserted mid-RIGHT -> all outputs take their reset values immediately, with o_fill=0.
REQ-036 SHALL cover this scenario: i_flush concurrent with a push at fill=3 -> o_fill=0 and o_underrun=0.
